// File: rtl/header_remover_pkg.sv
// Shared types and sizing helpers for the streaming header remover.
package header_remover_pkg;

  // Header capture vs. payload forwarding.
  typedef enum logic [0:0] {
    HDR     = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  // Number of stream beats that make up one header.
  function automatic int hdr_beats(input int header_size, input int data_width);
    return header_size / data_width;
  endfunction

  // Width of a counter able to hold 0..beats.
  function automatic int cnt_width(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Minimal Avalon-ST bundle: data, valid, ready, sop, eop.
interface avalon_st_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  sop;
  logic                  eop;

  modport master (output data, valid, sop, eop, input ready);
  modport slave  (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/st_pipe_reg.sv
// Single-stage Avalon-ST output register. A held beat (valid && !ready)
// keeps data/sop/eop stable; a new beat may load whenever the stage is
// empty or is being drained in the same cycle.
module st_pipe_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] beat_data,
  input  logic                  beat_sop,
  input  logic                  beat_eop,
  output logic                  can_load,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  sop,
  output logic                  eop
);

  assign can_load = ready || !valid;

  // Load a new beat, or retire the current one once it has been taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      sop   <= 1'b0;
      eop   <= 1'b0;
    end else if (load) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      valid <= 1'b1;
      data  <= beat_data;
      sop   <= beat_sop;
      eop   <= beat_eop;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/st_header_remover.sv
// Avalon-ST header stripper: captures the first HEADER_SIZE bits of each
// SOP-aligned packet onto header_data (first beat in the MSBs), strobes
// header_valid for one cycle, and forwards the remaining beats with SOP
// moved to the first payload beat.
// Optional: define HEADER_REMOVER_ERR_EN to add an `err` pulse output for
// early-EOP drops and SOP arriving during payload.
module st_header_remover
  import header_remover_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int HEADER_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  avalon_st_if.slave             data_in,
  output logic [HEADER_SIZE-1:0] header_data,
  output logic                   header_valid,
  avalon_st_if.master            data_out
`ifdef HEADER_REMOVER_ERR_EN
  ,
  output logic                   err
`endif
);

  localparam int HDR_BEATS = hdr_beats(HEADER_SIZE, DATA_WIDTH);
  localparam int CNT_W     = cnt_width(HDR_BEATS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(HDR_BEATS - 1);

  if (HEADER_SIZE <= 0 || (HEADER_SIZE % DATA_WIDTH) != 0) begin : g_bad_cfg
    $error("HEADER_SIZE must be a positive multiple of DATA_WIDTH");
  end

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       idx;
  logic [HEADER_SIZE-1:0] hdr_acc;
  logic [HEADER_SIZE-1:0] next_hdr;
  logic                   first_flag;
  logic                   in_ready;
  logic                   accept;
  logic                   hdr_take;
  logic                   hdr_last;
  logic                   pipe_load;
  logic                   pipe_can_load;

  assign data_in.ready = in_ready;

  // Handshake and header-beat decode for the current input beat.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves one unassigned and a latch is never inferred.
    in_ready  = 1'b1;
    pipe_load = 1'b0;
    if (state == PAYLOAD) in_ready = pipe_can_load;
    accept   = data_in.valid && in_ready;
    // A SOP always (re)starts a header, even mid-payload; otherwise only a
    // header already under way takes more beats.
    hdr_take = accept && (data_in.sop || (state == HDR && cnt != '0));
    idx      = data_in.sop ? '0 : cnt;
    hdr_last = (idx == LAST_IDX);
    next_hdr = (hdr_acc << DATA_WIDTH) | HEADER_SIZE'(data_in.data);
    if (accept && state == PAYLOAD && !data_in.sop) pipe_load = 1'b1;
  end

  // Header assembly, packet state and the one-cycle header strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= HDR;
      cnt          <= '0;
      hdr_acc      <= '0;
      header_data  <= '0;
      header_valid <= 1'b0;
      first_flag   <= 1'b0;
    end else begin
      header_valid <= 1'b0;
      if (hdr_take) begin
        if (hdr_last) begin
          header_data  <= next_hdr;
          header_valid <= 1'b1;
          cnt          <= '0;
          if (data_in.eop) begin
            state <= HDR;
          end else begin
            state      <= PAYLOAD;
            first_flag <= 1'b1;
          end
        end else if (data_in.eop) begin
          // Packet ended inside its header: drop it silently.
          cnt   <= '0;
          state <= HDR;
        end else begin
          hdr_acc <= next_hdr;
          cnt     <= idx + CNT_W'(1);
          state   <= HDR;
        end
      end else if (pipe_load) begin
        first_flag <= 1'b0;
        if (data_in.eop) state <= HDR;
      end
    end
  end

`ifdef HEADER_REMOVER_ERR_EN
  // Flag a truncated header or a packet cut short by a new SOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= hdr_take && ((state == PAYLOAD) || (!hdr_last && data_in.eop));
    end
  end
`endif

  st_pipe_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pipe_load),
    .beat_data(data_in.data),
    .beat_sop (first_flag),
    .beat_eop (data_in.eop),
    .can_load (pipe_can_load),
    .ready    (data_out.ready),
    .valid    (data_out.valid),
    .data     (data_out.data),
    .sop      (data_out.sop),
    .eop      (data_out.eop)
  );

endmodule

// File: tb/tb_st_header_remover.sv
// Scoreboard bench for st_header_remover: one DUT with 16-bit beats and a
// single-beat header, one with 8-bit beats and a two-beat header.
module tb_st_header_remover;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH(16)) i16 ();
  avalon_st_if #(.DATA_WIDTH(16)) o16 ();
  avalon_st_if #(.DATA_WIDTH(8))  i8 ();
  avalon_st_if #(.DATA_WIDTH(8))  o8 ();

  logic [15:0] hd16, hd8;
  logic        hv16, hv8;
`ifdef HEADER_REMOVER_ERR_EN
  logic        err16, err8;
  int          err_cnt16 = 0, err_cnt8 = 0;
  int          err_exp8 = 0;
`endif

  st_header_remover #(.DATA_WIDTH(16), .HEADER_SIZE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .data_in(i16), .header_data(hd16),
    .header_valid(hv16), .data_out(o16)
`ifdef HEADER_REMOVER_ERR_EN
    , .err(err16)
`endif
  );

  st_header_remover #(.DATA_WIDTH(8), .HEADER_SIZE(16)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .data_in(i8), .header_data(hd8),
    .header_valid(hv8), .data_out(o8)
`ifdef HEADER_REMOVER_ERR_EN
    , .err(err8)
`endif
  );

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
    logic        contig;  // must follow the previous beat with no gap
  } beat_t;

  beat_t       q16[$], q8[$];
  logic [15:0] hq16[$], hq8[$];
  int checks = 0, errors = 0;
  int cyc = 0;
  int mode16 = 0, mode8 = 0;  // 0: ready high, 1: toggle, 2: ready low

  always @(posedge clk) cyc++;

  function automatic beat_t mk(input logic [15:0] d, input logic s, input logic e,
                               input logic c);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.contig = c;
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Output-ready pattern generators.
  initial begin
    o16.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (mode16 == 0) o16.ready = 1'b1;
      else if (mode16 == 2) o16.ready = 1'b0;
      else o16.ready = ~o16.ready;
    end
  end

  initial begin
    o8.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (mode8 == 0) o8.ready = 1'b1;
      else if (mode8 == 2) o8.ready = 1'b0;
      else o8.ready = ~o8.ready;
    end
  end

  // Monitor for the 16-bit DUT.
  int          last16 = -10;
  logic        held16 = 1'b0;
  logic [17:0] hold16;
  always @(negedge clk) begin
    beat_t e;
    logic [15:0] h;
    if (!rst_n) begin
      held16 = 1'b0;
    end else begin
      if (held16) check("hold16", {o16.valid, o16.data, o16.sop, o16.eop}, {1'b1, hold16});
      held16 = o16.valid && !o16.ready;
      hold16 = {o16.data, o16.sop, o16.eop};
      if (o16.valid && o16.ready) begin
        if (q16.size() == 0) begin
          checks++; errors++;
          $display("FAIL dout16_extra actual=0x%0h required=none", o16.data);
        end else begin
          e = q16.pop_front();
          check("dout16", {o16.data, o16.sop, o16.eop}, {e.data, e.sop, e.eop});
          if (e.contig) check("gap16", cyc, last16 + 1);
        end
        last16 = cyc;
      end
      if (hv16) begin
        if (hq16.size() == 0) begin
          checks++; errors++;
          $display("FAIL hdr16_extra actual=0x%0h required=none", hd16);
        end else begin
          h = hq16.pop_front();
          check("hdr16", hd16, h);
        end
      end
      if (!i16.ready) check("in_ready16", o16.valid && !o16.ready, 1);
    end
  end

  // Monitor for the 8-bit DUT.
  int          last8 = -10;
  logic        held8 = 1'b0;
  logic [9:0]  hold8;
  always @(negedge clk) begin
    beat_t e;
    logic [15:0] h;
    if (!rst_n) begin
      held8 = 1'b0;
    end else begin
      if (held8) check("hold8", {o8.valid, o8.data, o8.sop, o8.eop}, {1'b1, hold8});
      held8 = o8.valid && !o8.ready;
      hold8 = {o8.data, o8.sop, o8.eop};
      if (o8.valid && o8.ready) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL dout8_extra actual=0x%0h required=none", o8.data);
        end else begin
          e = q8.pop_front();
          check("dout8", {8'h00, o8.data, o8.sop, o8.eop}, {e.data, e.sop, e.eop});
          if (e.contig) check("gap8", cyc, last8 + 1);
        end
        last8 = cyc;
      end
      if (hv8) begin
        if (hq8.size() == 0) begin
          checks++; errors++;
          $display("FAIL hdr8_extra actual=0x%0h required=none", hd8);
        end else begin
          h = hq8.pop_front();
          check("hdr8", hd8, h);
        end
      end
      if (!i8.ready) check("in_ready8", o8.valid && !o8.ready, 1);
    end
  end

`ifdef HEADER_REMOVER_ERR_EN
  always @(negedge clk) begin
    if (rst_n && err16) err_cnt16++;
    if (rst_n && err8) err_cnt8++;
  end
`endif

  task automatic send16(input logic [15:0] d, input logic s, input logic e);
    int n = 0;
    bit ok = 1'b0;
    i16.data = d; i16.sop = s; i16.eop = e; i16.valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk); ok = i16.ready;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send16_timeout actual=stalled required=accepted data=0x%0h", d);
    end
  endtask

  task automatic send8(input logic [7:0] d, input logic s, input logic e);
    int n = 0;
    bit ok = 1'b0;
    i8.data = d; i8.sop = s; i8.eop = e; i8.valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk); ok = i8.ready;
      @(posedge clk); #1;
      n++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send8_timeout actual=stalled required=accepted data=0x%0h", d);
    end
  endtask

  task automatic idle16();
    i16.valid = 1'b0; i16.sop = 1'b0; i16.eop = 1'b0;
  endtask

  task automatic idle8();
    i8.valid = 1'b0; i8.sop = 1'b0; i8.eop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle16(); idle8();
    i16.data = '0; i8.data = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state.
    check("rst_hdr16", hd16, 16'h0000);
    check("rst_hv16", hv16, 0);
    check("rst_out16", {o16.valid, o16.sop, o16.eop, o16.data}, 0);
    check("rst_hdr8", hd8, 16'h0000);
    check("rst_hv8", hv8, 0);
    check("rst_out8", {o8.valid, o8.sop, o8.eop, o8.data}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 16-bit beats, single-beat header, data 0..9, no backpressure.
    hq16.push_back(16'h0000);
    for (int i = 1; i <= 9; i++) q16.push_back(mk(16'(i), i == 1, i == 9, i > 1));
    for (int i = 0; i <= 9; i++) send16(16'(i), i == 0, i == 9);
    idle16();
    repeat (4) @(posedge clk); #1;

    // 16-bit beats with toggling downstream ready.
    mode16 = 1;
    hq16.push_back(16'h0100);
    for (int i = 1; i <= 9; i++) q16.push_back(mk(16'h0100 + 16'(i), i == 1, i == 9, 1'b0));
    for (int i = 0; i <= 9; i++) send16(16'h0100 + 16'(i), i == 0, i == 9);
    idle16();
    repeat (8) @(posedge clk);
    mode16 = 0;
    repeat (2) @(posedge clk); #1;

    // 8-bit beats, two-beat header, data 0..9.
    hq8.push_back(16'h0001);
    for (int i = 2; i <= 9; i++) q8.push_back(mk(16'(i), i == 2, i == 9, i > 2));
    for (int i = 0; i <= 9; i++) send8(8'(i), i == 0, i == 9);
    idle8();
    repeat (3) @(posedge clk); #1;

    // Header-only packet.
    hq8.push_back(16'hABCD);
    send8(8'hAB, 1'b1, 1'b0);
    send8(8'hCD, 1'b0, 1'b1);
    idle8();
    repeat (3) @(posedge clk); #1;

    // Early EOP on the first header beat: nothing comes out.
    send8(8'h55, 1'b1, 1'b1);
    idle8();
`ifdef HEADER_REMOVER_ERR_EN
    err_exp8++;
`endif
    repeat (3) @(posedge clk); #1;

    // Stray beats with no SOP, then a valid packet.
    send8(8'h11, 1'b0, 1'b0);
    send8(8'h22, 1'b0, 1'b0);
    idle8();
    hq8.push_back(16'h3031);
    q8.push_back(mk(16'h0032, 1'b1, 1'b0, 1'b0));
    q8.push_back(mk(16'h0033, 1'b0, 1'b1, 1'b1));
    send8(8'h30, 1'b1, 1'b0);
    send8(8'h31, 1'b0, 1'b0);
    send8(8'h32, 1'b0, 1'b0);
    send8(8'h33, 1'b0, 1'b1);
    idle8();
    repeat (3) @(posedge clk); #1;

    // Toggling downstream ready on the 8-bit path.
    mode8 = 1;
    hq8.push_back(16'h4041);
    for (int i = 2; i <= 7; i++) q8.push_back(mk(16'h0040 + 16'(i), i == 2, i == 7, 1'b0));
    for (int i = 0; i <= 7; i++) send8(8'h40 + 8'(i), i == 0, i == 7);
    idle8();
    repeat (8) @(posedge clk);
    mode8 = 0;
    repeat (2) @(posedge clk); #1;

    // SOP arrives mid-payload: previous packet ends without EOP.
    hq8.push_back(16'h5051);
    hq8.push_back(16'h6061);
    q8.push_back(mk(16'h0052, 1'b1, 1'b0, 1'b0));
    q8.push_back(mk(16'h0053, 1'b0, 1'b0, 1'b1));
    q8.push_back(mk(16'h0062, 1'b1, 1'b1, 1'b0));
    send8(8'h50, 1'b1, 1'b0);
    send8(8'h51, 1'b0, 1'b0);
    send8(8'h52, 1'b0, 1'b0);
    send8(8'h53, 1'b0, 1'b0);
    send8(8'h60, 1'b1, 1'b0);
    send8(8'h61, 1'b0, 1'b0);
    send8(8'h62, 1'b0, 1'b1);
    idle8();
`ifdef HEADER_REMOVER_ERR_EN
    err_exp8++;
`endif
    repeat (3) @(posedge clk); #1;

    // Reset while a payload beat is held in the output register.
    mode8 = 2;
    repeat (2) @(posedge clk); #1;
    hq8.push_back(16'h7071);
    send8(8'h70, 1'b1, 1'b0);
    send8(8'h71, 1'b0, 1'b0);
    send8(8'h72, 1'b0, 1'b0);
    idle8();
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hdr8", hd8, 16'h0000);
    check("midrst_hv8", hv8, 0);
    check("midrst_out8", {o8.valid, o8.sop, o8.eop, o8.data}, 0);
    check("midrst_ready8", i8.ready, 1);
    @(negedge clk);
    @(negedge clk);
    mode8 = 0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    hq8.push_back(16'h8081);
    q8.push_back(mk(16'h0082, 1'b1, 1'b0, 1'b0));
    q8.push_back(mk(16'h0083, 1'b0, 1'b1, 1'b1));
    send8(8'h80, 1'b1, 1'b0);
    send8(8'h81, 1'b0, 1'b0);
    send8(8'h82, 1'b0, 1'b0);
    send8(8'h83, 1'b0, 1'b1);
    idle8();
    repeat (10) @(posedge clk); #1;

    // Everything expected must have been seen.
    check("left_dout16", q16.size(), 0);
    check("left_hdr16", hq16.size(), 0);
    check("left_dout8", q8.size(), 0);
    check("left_hdr8", hq8.size(), 0);
`ifdef HEADER_REMOVER_ERR_EN
    check("err16_count", err_cnt16, 0);
    check("err8_count", err_cnt8, err_exp8);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
